efcdt_scheduler: RTL and testbench
==================================

# efcdt_scheduler

Shares one combinational EFCDT decision-tree classifier instance among NCH measurement channels. Each channel presents a six-value sample (Va, Vb, Vc, Ia, Ib, Ic) on a valid/ready handshake. A round-robin arbiter selects one sample per cycle and drives it into the classifier through registered outputs. The block then captures the resulting class, tags it with the channel ID and applies per-channel persistence filtering before handing the result downstream.

## Interface
- N, 8, sample field width; must match the classifier's N.
- C, 3, class width; must match the classifier's C.
- NCH, 4, number of requesting channels; must be ≥2.
- PERSIST, 3, consecutive identical non-zero classes required to confirm a fault; must be ≥1.

- clk  in  1  single clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  NCH  per-channel sample valid.
- in_ready  out  NCH  per-channel accept; at most one bit is set per cycle.
- in_data  in  NCH*6*N  channel i occupies [i*6N +: 6N], packed {Va,Vb,Vc,Ia,Ib,Ic} with Va in the MSBs.
- dt_Va, dt_Vb, dt_Vc, dt_Ia, dt_Ib, dt_Ic  out  N each  registered sample driven to the classifier.
- dt_cls  in  C  combinational classifier result.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accept.
- out_ch  out  $clog2(NCH)  source channel of the result.
- out_cls  out  C  class; values above 5 are forced to 0.
- out_confirmed  out  1  class is non-zero and has persisted PERSIST times on this channel.
- err  out  1  sticky flag: classifier returned a class value above 5.

## Operation
- Two-stage pipeline:
  - S1 holds the sample being classified: s1_v, s1_ch, and the dt_* registers.
  - S2 holds the result: out_valid, out_ch, out_cls, out_confirmed.
- Stall rules:
  - s2_free = !out_valid | out_ready.
  - s1_free = !s1_v | s2_free.
- Arbitration:
  - When s1_free, grant the first channel with in_valid set, searching cyclically from rr_ptr upward.
  - in_ready[g] = 1 for the granted channel only; in_ready = 0 when !s1_free.
- Transfer on channel i occurs when in_valid[i] & in_ready[i]. On transfer:
  - load S1 from channel i's in_data field;
  - set s1_ch = i and s1_v = 1;
  - set rr_ptr = (i+1) mod NCH.
- rr_ptr is unchanged on cycles with no grant.
- S1→S2 when s1_v & s2_free:
  - capture dt_cls into out_cls (mapped), s1_ch into out_ch, and set out_valid = 1;
  - if no new grant lands that cycle, clear s1_v.
- If s2_free and !s1_v, out_valid clears.
- Persistence, per channel, updated at the S1→S2 capture using the mapped class k:
  - last_cls[ch] and cnt[ch] (saturating at PERSIST).
  - If k == last_cls[ch], cnt = min(cnt+1, PERSIST); otherwise last_cls = k and cnt = 1.
  - out_confirmed = (k != 0) & (updated cnt == PERSIST).
- Class mapping: dt_cls > 5 produces out_cls = 0 and sets err. err clears only on rst.
- Holding: while out_valid & !out_ready, all S2 outputs are held stable. S1 and dt_* are held while S1 cannot advance.

## Timing
- Reset values:
  - in_ready = 0; rr_ptr = 0; s1_v = 0.
  - dt_* = 0.
  - out_valid = 0, out_ch = 0, out_cls = 0, out_confirmed = 0.
  - all last_cls = 0, all cnt = 0; err = 0.
- Latency: a sample accepted at edge k appears on dt_* after edge k. Its result appears with out_valid after edge k+1, i.e. 2 cycles.
- Throughput: 1 sample per cycle with out_ready held high.
- in_ready is combinational from in_valid, rr_ptr, s1_v, out_valid and out_ready. There is no combinational path from in_data to any output.
- Simultaneous in_valid on all channels: grants rotate strictly. No channel waits more than NCH-1 grants.
- Full pipeline: with S1 and S2 both occupied and out_ready = 0, in_ready = 0 on every channel. When out_ready rises, one new sample is accepted in that same cycle.
- Reset mid-operation: in-flight S1/S2 contents are discarded, no out_valid is emitted, and persistence history is cleared.

## Test plan
- Reset, then drive only channel 2 with valid held high and out_ready = 1 → in_ready[2] every cycle; first out_valid 2 cycles after the first accept, out_ch = 2, out_cls = stub dt_cls.
- All 4 channels valid continuously, out_ready = 1 → grant order 0,1,2,3,0,…; output order matches with 2-cycle lag.
- out_ready low for 5 cycles mid-stream → exactly two samples held in flight, in_ready = 0, out_* stable; no loss or duplication after release.
- Channel 1 fed with stub dt_cls = 3 three times, then 0 → out_confirmed = 0,0,1,0. The same sequence interleaved with channel 0 traffic gives the identical channel-1 result.
- Stub dt_cls = 7 → out_cls = 0 and err = 1, still set after 10 further normal results; cleared by rst.
- Assert rst while S1 and S2 are full → all outputs zero immediately. After release, the next accept is channel 0 and there is no stale out_valid.

Source files
------------

// File: rtl/efcdt_scheduler.sv
// Round-robin front end that time-shares one combinational EFCDT classifier
// among NCH channels, with per-channel persistence filtering on the result.
module efcdt_scheduler #(
  parameter int N       = 8,
  parameter int C       = 3,
  parameter int NCH     = 4,
  parameter int PERSIST = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           in_valid,
  output logic [NCH-1:0]           in_ready,
  input  logic [NCH*6*N-1:0]       in_data,
  output logic [N-1:0]             dt_Va,
  output logic [N-1:0]             dt_Vb,
  output logic [N-1:0]             dt_Vc,
  output logic [N-1:0]             dt_Ia,
  output logic [N-1:0]             dt_Ib,
  output logic [N-1:0]             dt_Ic,
  input  logic [C-1:0]             dt_cls,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(NCH)-1:0]   out_ch,
  output logic [C-1:0]             out_cls,
  output logic                     out_confirmed,
  output logic                     err
);

  localparam int CHW = $clog2(NCH);
  localparam int CW  = $clog2(PERSIST + 1);
  localparam int SW  = 6 * N;

  function automatic logic cls_bad(input logic [C-1:0] c);
    return 32'(c) > 32'd5;
  endfunction

  function automatic logic [C-1:0] map_cls(input logic [C-1:0] c);
    return cls_bad(c) ? '0 : c;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c >= CW'(PERSIST)) ? CW'(PERSIST) : c + CW'(1);
  endfunction

  logic             s1_v;
  logic [CHW-1:0]   s1_ch;
  logic [CHW-1:0]   rr_ptr;
  logic [CHW-1:0]   grant_idx;
  logic [CHW-1:0]   ptr_next;
  logic             grant_any;
  logic             s2_free;
  logic             s1_free;
  logic             xfer;
  logic             capture;
  logic [SW-1:0]    sample;
  logic [C-1:0]     cls_k;
  logic [CW-1:0]    cnt_new;
  logic             conf_new;
  logic [C-1:0]     last_cls [NCH];
  logic [CW-1:0]    cnt      [NCH];

  assign s2_free = !out_valid || out_ready;
  assign s1_free = !s1_v || s2_free;

  // Descending scan so the lowest offset from rr_ptr wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (in_valid[(int'(rr_ptr) + k) % NCH]) begin
        grant_any = 1'b1;
        grant_idx = CHW'((int'(rr_ptr) + k) % NCH);
      end
    end
  end

  assign xfer     = grant_any && s1_free && !rst;
  assign ptr_next = (grant_idx == CHW'(NCH - 1)) ? '0 : grant_idx + CHW'(1);
  assign sample   = in_data[int'(grant_idx)*SW +: SW];

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant_idx] = 1'b1;
  end

  // Stage 1: sample presented to the classifier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_ch  <= '0;
      rr_ptr <= '0;
      dt_Va  <= '0;
      dt_Vb  <= '0;
      dt_Vc  <= '0;
      dt_Ia  <= '0;
      dt_Ib  <= '0;
      dt_Ic  <= '0;
    end else if (xfer) begin
      s1_v   <= 1'b1;
      s1_ch  <= grant_idx;
      rr_ptr <= ptr_next;
      dt_Va  <= sample[5*N +: N];
      dt_Vb  <= sample[4*N +: N];
      dt_Vc  <= sample[3*N +: N];
      dt_Ia  <= sample[2*N +: N];
      dt_Ib  <= sample[1*N +: N];
      dt_Ic  <= sample[0*N +: N];
    end else if (s1_v && s2_free) begin
      s1_v <= 1'b0;
    end
  end

  assign capture  = s1_v && s2_free;
  assign cls_k    = map_cls(dt_cls);
  assign cnt_new  = (cls_k == last_cls[s1_ch]) ? sat_inc(cnt[s1_ch]) : CW'(1);
  assign conf_new = (cls_k != '0) && (cnt_new == CW'(PERSIST));

  // Stage 2: tagged, filtered result held until downstream accepts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_ch        <= '0;
      out_cls       <= '0;
      out_confirmed <= 1'b0;
      err           <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        last_cls[i] <= '0;
        cnt[i]      <= '0;
      end
    end else if (capture) begin
      out_valid       <= 1'b1;
      out_ch          <= s1_ch;
      out_cls         <= cls_k;
      out_confirmed   <= conf_new;
      last_cls[s1_ch] <= cls_k;
      cnt[s1_ch]      <= cnt_new;
      if (cls_bad(dt_cls)) err <= 1'b1;
    end else if (s2_free) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_efcdt_scheduler.sv
// Directed bench for efcdt_scheduler; the classifier stub returns dt_Va[2:0].
module tb_efcdt_scheduler;

  localparam int N = 8, C = 3, NCH = 4, PERSIST = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NCH-1:0]     in_valid = '0;
  logic [NCH-1:0]     in_ready;
  logic [NCH*6*N-1:0] in_data = '0;
  logic [N-1:0]       dt_Va, dt_Vb, dt_Vc, dt_Ia, dt_Ib, dt_Ic;
  logic [C-1:0]       dt_cls;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [1:0]         out_ch;
  logic [C-1:0]       out_cls;
  logic               out_confirmed;
  logic               err;

  int n_cmp = 0;
  int n_bad = 0;

  int seq1[4]  = '{3, 3, 3, 0};
  int conf1[4] = '{0, 0, 1, 0};
  int conf0[4] = '{0, 0, 1, 1};

  always #5 clk = ~clk;

  assign dt_cls = dt_Va[2:0];

  efcdt_scheduler #(.N(N), .C(C), .NCH(NCH), .PERSIST(PERSIST)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dt_Va(dt_Va), .dt_Vb(dt_Vb), .dt_Vc(dt_Vc),
    .dt_Ia(dt_Ia), .dt_Ib(dt_Ib), .dt_Ic(dt_Ic),
    .dt_cls(dt_cls),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_cls(out_cls), .out_confirmed(out_confirmed), .err(err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6*N-1:0] smp(input int tag, input int cls);
    return {8'(tag*8 + cls), 8'(tag), 8'hA5, 8'h5A, 8'(tag + 1), 8'(cls)};
  endfunction

  task automatic set_ch(input int ch, input int tag, input int cls);
    in_data[ch*6*N +: 6*N] = smp(tag, cls);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state, with requests pending to show in_ready is held low
    in_valid = 4'b1111;
    tick();
    tick();
    #1;
    check("rst_rdy",   64'(in_ready), 64'(0));
    check("rst_vld",   64'(out_valid), 64'(0));
    check("rst_ch",    64'(out_ch), 64'(0));
    check("rst_cls",   64'(out_cls), 64'(0));
    check("rst_conf",  64'(out_confirmed), 64'(0));
    check("rst_err",   64'(err), 64'(0));
    check("rst_dtva",  64'(dt_Va), 64'(0));
    in_valid = '0;
    rst = 1'b0;

    // A: channel 2 alone
    tick();
    in_valid = 4'b0100;
    set_ch(2, 1, 2);
    #1;
    check("A_rdy0", 64'(in_ready), 64'(4'b0100));
    tick();
    check("A_dtva", 64'(dt_Va), 64'(10));
    check("A_dtvc", 64'(dt_Vc), 64'(8'hA5));
    check("A_vld0", 64'(out_valid), 64'(0));
    set_ch(2, 2, 2);
    #1;
    check("A_rdy1", 64'(in_ready), 64'(4'b0100));
    tick();
    check("A_vld1", 64'(out_valid), 64'(1));
    check("A_ch",   64'(out_ch), 64'(2));
    check("A_cls",  64'(out_cls), 64'(2));
    check("A_conf", 64'(out_confirmed), 64'(0));
    check("A_dtva2", 64'(dt_Va), 64'(18));
    in_valid = '0;
    tick();
    check("A_vld2", 64'(out_valid), 64'(1));
    tick();
    check("A_drain", 64'(out_valid), 64'(0));

    // B: all channels requesting, strict rotation
    do_reset();
    for (int i = 0; i < NCH; i++) set_ch(i, 20 + i, i + 1);
    in_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    for (int c = 0; c < 8; c++) begin
      check("B_rdy", 64'(in_ready), 64'(1 << (c % 4)));
      tick();
      if (c >= 1) begin
        check("B_vld", 64'(out_valid), 64'(1));
        check("B_ch",  64'(out_ch), 64'((c - 1) % 4));
        check("B_cls", 64'(out_cls), 64'((c - 1) % 4 + 1));
      end else begin
        check("B_vld0", 64'(out_valid), 64'(0));
      end
    end

    // C: backpressure with both stages full
    out_ready = 1'b0;
    #1;
    for (int s = 0; s < 6; s++) begin
      check("C_rdy",  64'(in_ready), 64'(0));
      check("C_vld",  64'(out_valid), 64'(1));
      check("C_ch",   64'(out_ch), 64'(2));
      check("C_cls",  64'(out_cls), 64'(3));
      check("C_dtva", 64'(dt_Va), 64'(188));
      if (s < 5) tick();
    end
    out_ready = 1'b1;
    #1;
    check("C_rdy_rel", 64'(in_ready), 64'(4'b0001));
    tick();
    check("C_ch3",  64'(out_ch), 64'(3));
    check("C_cls3", 64'(out_cls), 64'(4));
    tick();
    check("C_ch0",  64'(out_ch), 64'(0));
    check("C_cls0", 64'(out_cls), 64'(1));
    tick();
    check("C_ch1",  64'(out_ch), 64'(1));
    check("C_cls1", 64'(out_cls), 64'(2));
    in_valid = '0;

    // D1: persistence on channel 1 alone
    do_reset();
    for (int j = 0; j <= 4; j++) begin
      if (j < 4) begin
        in_valid = 4'b0010;
        set_ch(1, j, seq1[j]);
      end else begin
        in_valid = '0;
      end
      tick();
      if (j >= 1) begin
        check("D1_vld",  64'(out_valid), 64'(1));
        check("D1_ch",   64'(out_ch), 64'(1));
        check("D1_cls",  64'(out_cls), 64'(seq1[j-1]));
        check("D1_conf", 64'(out_confirmed), 64'(conf1[j-1]));
      end
    end

    // D2: same channel-1 sequence interleaved with channel 0
    do_reset();
    for (int g = 0; g <= 8; g++) begin
      if (g < 8) begin
        in_valid = 4'b0011;
        set_ch(0, g, 5);
        set_ch(1, g, seq1[g/2]);
        #1;
        check("D2_rdy", 64'(in_ready), 64'(1 << (g % 2)));
      end else begin
        in_valid = '0;
      end
      tick();
      if (g >= 1) begin
        check("D2_vld", 64'(out_valid), 64'(1));
        check("D2_ch",  64'(out_ch), 64'((g - 1) % 2));
        if ((g - 1) % 2 == 1) begin
          check("D2_cls1",  64'(out_cls), 64'(seq1[(g-1)/2]));
          check("D2_conf1", 64'(out_confirmed), 64'(conf1[(g-1)/2]));
        end else begin
          check("D2_cls0",  64'(out_cls), 64'(5));
          check("D2_conf0", 64'(out_confirmed), 64'(conf0[(g-1)/2]));
        end
      end
    end

    // E: out-of-range class
    do_reset();
    in_valid = 4'b0001;
    set_ch(0, 1, 7);
    tick();
    set_ch(0, 2, 1);
    tick();
    check("E_vld",  64'(out_valid), 64'(1));
    check("E_cls",  64'(out_cls), 64'(0));
    check("E_conf", 64'(out_confirmed), 64'(0));
    check("E_err",  64'(err), 64'(1));
    repeat (10) tick();
    in_valid = '0;
    tick();
    check("E_cls_ok",  64'(out_cls), 64'(1));
    check("E_conf_ok", 64'(out_confirmed), 64'(1));
    check("E_err_sticky", 64'(err), 64'(1));
    do_reset();
    check("E_err_clr", 64'(err), 64'(0));

    // F: reset while both stages are full
    out_ready = 1'b0;
    set_ch(0, 6, 1);
    set_ch(1, 3, 5);
    set_ch(2, 4, 6);
    set_ch(3, 5, 2);
    in_valid = 4'b1110;
    tick();
    tick();
    check("F_full_rdy", 64'(in_ready), 64'(0));
    check("F_full_vld", 64'(out_valid), 64'(1));
    check("F_full_ch",  64'(out_ch), 64'(1));
    check("F_full_cls", 64'(out_cls), 64'(5));
    check("F_full_dt",  64'(dt_Va), 64'(38));
    rst = 1'b1;
    #1;
    check("F_rst_vld", 64'(out_valid), 64'(0));
    check("F_rst_ch",  64'(out_ch), 64'(0));
    check("F_rst_cls", 64'(out_cls), 64'(0));
    check("F_rst_dt",  64'(dt_Va), 64'(0));
    check("F_rst_rdy", 64'(in_ready), 64'(0));
    tick();
    in_valid = 4'b1111;
    out_ready = 1'b1;
    rst = 1'b0;
    #1;
    check("F_rel_rdy", 64'(in_ready), 64'(4'b0001));
    check("F_rel_vld", 64'(out_valid), 64'(0));
    tick();
    check("F_s1_vld", 64'(out_valid), 64'(0));
    check("F_s1_dt",  64'(dt_Va), 64'(49));
    tick();
    check("F_out_vld", 64'(out_valid), 64'(1));
    check("F_out_ch",  64'(out_ch), 64'(0));
    check("F_out_cls", 64'(out_cls), 64'(1));
    in_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
